// File: rtl/divisor_pkg.sv
// Shared types and constants for the divisor arbiter slice: FSM states,
// bus width of the serial Divisor unit and the divide-by-zero quotient.
package divisor_pkg;

   localparam int DATA_W = 6;
   localparam logic [DATA_W-1:0] DZ_QUOT = 6'h3F;

   typedef enum logic [2:0] {
      IDLE,
      LD_DEND,
      LD_DSOR,
      WAIT,
      RD_Q,
      RD_R,
      DONE
   } state_t;

   // Round-robin successor of an index in a ring of n entries.
   function automatic int wrapInc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request bit
// found at or after the pointer, wrapping past the top index.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt
);

   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = PTR_W'((int'(i_ptr) + i) % NREQ);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/divisor_arbiter.sv
// Shares one bus-serial Divisor among NREQ requesters with round-robin grant.
// Optional macro DIVZERO_CHK_EN short-circuits zero divisors and adds dz_err.
module divisor_arbiter
   import divisor_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int DIV_LATENCY = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] dividend,
   input  logic [NREQ*DATA_W-1:0] divisor,
   output logic [NREQ-1:0]        gnt,
   output logic                   done,
   output logic [DATA_W-1:0]      quotient,
   output logic [DATA_W-1:0]      remainder,
   output logic                   busy,
   output logic                   div_start,
   output logic [DATA_W-1:0]      div_in,
   input  logic [DATA_W-1:0]      div_out
`ifdef DIVZERO_CHK_EN
   ,
   output logic                   dz_err
`endif
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

   state_t              r_state;
   state_t              w_nextState;
   logic [NREQ-1:0]     r_gnt;
   logic [PTR_W-1:0]    r_owner;
   logic [PTR_W-1:0]    r_rrPtr;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_quot;
   logic [DATA_W-1:0]   r_rem;
   logic [NREQ-1:0]     w_arbGnt;
   logic [PTR_W-1:0]    w_arbIdx;
   logic [DATA_W-1:0]   w_ownDend;
   logic [DATA_W-1:0]   w_ownDsor;
   logic                w_divZero;
`ifdef DIVZERO_CHK_EN
   logic                r_dzErr;
`endif

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rrArbiter (
      .i_req (req),
      .i_ptr (r_rrPtr),
      .o_gnt (w_arbGnt)
   );

   always_comb begin
      w_arbIdx  = '0;
      w_ownDend = '0;
      w_ownDsor = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_arbGnt[i]) begin
            w_arbIdx = PTR_W'(i);
         end
         if (r_owner == PTR_W'(i)) begin
            w_ownDend = dividend[i*DATA_W +: DATA_W];
            w_ownDsor = divisor[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef DIVZERO_CHK_EN
   assign w_divZero = (w_ownDsor == '0);
`else
   assign w_divZero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      div_start   = 1'b0;
      div_in      = '0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_nextState = LD_DEND;
            end
         end
         LD_DEND: begin
            if (w_divZero) begin
               w_nextState = DONE;
            end else begin
               div_start   = 1'b1;
               div_in      = w_ownDend;
               w_nextState = LD_DSOR;
            end
         end
         LD_DSOR: begin
            div_in      = w_ownDsor;
            w_nextState = WAIT;
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_nextState = RD_Q;
            end
         end
         RD_Q:    w_nextState = RD_R;
         RD_R:    w_nextState = DONE;
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Ownership, latency counter and result capture follow the FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt   <= '0;
         r_owner <= '0;
         r_rrPtr <= '0;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
`ifdef DIVZERO_CHK_EN
         r_dzErr <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt   <= w_arbGnt;
                  r_owner <= w_arbIdx;
`ifdef DIVZERO_CHK_EN
                  r_dzErr <= 1'b0;
`endif
               end
            end
            LD_DEND: begin
               if (w_divZero) begin
                  r_quot  <= DZ_QUOT;
                  r_rem   <= w_ownDend;
`ifdef DIVZERO_CHK_EN
                  r_dzErr <= 1'b1;
`endif
               end
            end
            LD_DSOR: r_cnt <= CNT_W'(DIV_LATENCY - 1);
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RD_Q:    r_quot <= div_out;
            RD_R:    r_rem  <= div_out;
            DONE: begin
               r_gnt   <= '0;
               r_rrPtr <= PTR_W'(wrapInc(int'(r_owner), NREQ));
            end
            default: ;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign busy      = (r_state != IDLE);
   assign quotient  = r_quot;
   assign remainder = r_rem;
`ifdef DIVZERO_CHK_EN
   assign dz_err    = done & r_dzErr;
`endif

endmodule
